robs_divider: RTL and testbench

Sequential signed two's-complement divider, the inverse counterpart of the Robertson's multiplier datapath in this lab. It takes a WIDTH-bit dividend and divisor and produces a truncated quotient and remainder. It runs one non-restoring iteration per clock, with an integrated control FSM and a down-counter. It sits beside the multiplier on the same operand buses and uses a start/done handshake.

---
 rtl/robs_divider.sv | 152 +++++++++++++++
 tb/tb_robs_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/robs_divider.sv
// Sequential signed divider: one non-restoring iteration per clock, with an
// integrated IDLE/LOAD/ITER/FIX/DONE controller and a down-counter.
module robs_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] d_abs_q, d_abs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // Datapath helpers for one non-restoring step and the final remainder restore.
  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] p_fix;

  // The settled remainder is always below |divisor|, so WIDTH bits are enough.
  assign p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign p_step = p_q[WIDTH] ? (p_sh + {1'b0, d_abs_q}) : (p_sh - {1'b0, d_abs_q});
  assign p_fix  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_abs_q) : p_q[WIDTH-1:0];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    d_abs_d   = d_abs_q;
    q_d       = q_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dvd_neg_d = dvd_q[WIDTH-1];
        dvs_neg_d = dvs_q[WIDTH-1];
        q_d       = dvd_q[WIDTH-1] ? (WIDTH'(0) - dvd_q) : dvd_q;
        d_abs_d   = dvs_q[WIDTH-1] ? (WIDTH'(0) - dvs_q) : dvs_q;
        p_d       = '0;
        cnt_d     = CW'(WIDTH);
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        p_d   = p_step;
        q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = (dvd_neg_q ^ dvs_neg_q) ? (WIDTH'(0) - q_q) : q_q;
        rem_d   = dvd_neg_q ? (WIDTH'(0) - p_fix) : p_fix;
        dbz_d   = 1'b0;
        ovf_d   = (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      d_abs_q   <= '0;
      q_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      d_abs_q   <= d_abs_d;
      q_q       <= q_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_robs_divider.sv
// Self-checking bench for robs_divider: directed corners, handshake and reset
// scenarios, then random operands against an integer-arithmetic reference.
module tb_robs_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  int n_checks = 0;
  int n_fails  = 0;

  robs_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer / and % with the result wrapped into WIDTH bits.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                output logic dz, output logic ov);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      q  = WIDTH'(ai / bi);
      r  = WIDTH'(ai % bi);
      dz = 1'b0;
      ov = (ai / bi) > ((1 << (WIDTH - 1)) - 1);
    end
  endfunction

  // Sampled on falling edges; returns edges from the accepting edge to done.
  task automatic wait_done(input bit noise, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (noise && (lat == 3 || lat == 5)) begin
        start    = 1'b1;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
      end else if (noise) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noise);
    logic [WIDTH-1:0] eq, er;
    logic             edz, eov;
    int               lat, bc, exp_lat;
    model(a, b, eq, er, edz, eov);
    exp_lat = (b == '0) ? 1 : WIDTH + 2;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + WIDTH'(1);
    wait_done(noise, lat, bc);
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("busy_cycles", bc, exp_lat);
    check("busy_in_done", busy, 1'b0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    check("overflow", overflow, eov);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("quotient_hold", quotient, eq);
    check("remainder_hold", remainder, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] eq, er, a, b;
    logic             edz, eov;
    int               lat, bc;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;

    do_op(8'd100, 8'd7, 1'b0);
    check("q_100_7_const", quotient, 8'd14);
    check("r_100_7_const", remainder, 8'd2);
    do_op(-8'sd100, 8'd7, 1'b0);
    do_op(8'd100, -8'sd7, 1'b0);
    do_op(-8'sd100, -8'sd7, 1'b0);
    do_op(8'd3, 8'd10, 1'b0);
    do_op(8'h80, 8'hFF, 1'b0);
    check("ovf_const", overflow, 1'b1);
    do_op(8'h80, 8'd1, 1'b0);
    do_op(8'd127, 8'd127, 1'b0);
    do_op(8'd5, 8'd0, 1'b0);
    check("dbz_q_const", quotient, 8'hFF);
    do_op(8'd9, 8'd3, 1'b0);
    do_op(8'd100, 8'd7, 1'b1);
    do_op(-8'sd77, 8'd9, 1'b1);

    // Start held high across two operations: no IDLE cycle between them.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    wait_done(1'b0, lat, bc);
    check("b2b_first_latency", lat, WIDTH + 2);
    check("b2b_first_q", quotient, 8'd14);
    dividend = -8'sd100;
    divisor  = 8'd7;
    @(negedge clk);
    wait_done(1'b0, lat, bc);
    start = 1'b0;
    model(-8'sd100, 8'd7, eq, er, edz, eov);
    check("b2b_gap", lat + 1, WIDTH + 3);
    check("b2b_second_q", quotient, eq);
    check("b2b_second_r", remainder, er);

    // Asynchronous reset between edges during ITER.
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd6;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_quotient", quotient, 0);
    check("arst_remainder", remainder, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", div_by_zero, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    do_op(8'd50, 8'd6, 1'b0);
    check("q_50_6_const", quotient, 8'd8);
    check("r_50_6_const", remainder, 8'd2);

    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 8'hFF;
        2:       b = 8'h80;
        default: b = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      do_op(a, b, (b != '0) && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
